hex_scanner: RTL
================

HEX_SCANNER -- requirements
Module: hex_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles each digit stays lit; legal range is 1 or more.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: number of scanned digits, each showing one nibble of data.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port load_data, input, 4*NUM_DIGITS bits: the value to display; nibble k goes to digit k.
REQ-006 SHALL have port load_valid, input, 1 bit: load_data is offered this cycle.
REQ-007 SHALL have port load_ready, output, 1 bit: the block can accept an offer this cycle.
REQ-008 SHALL have port digit_val, output, 4 bits: nibble of the active digit, fed to the downstream 7-segment decoder.
REQ-009 SHALL have port digit_en_n, output, NUM_DIGITS bits: active-low one-hot digit enable.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse at each scan-frame boundary.

Function
REQ-011 SHALL drive every output from registered state only; no combinational path from any input to any output.
REQ-012 SHALL run the divider from 0 to REFRESH_DIV-1; tick is asserted when the count equals REFRESH_DIV-1, and the count returns to 0 on the same edge.
REQ-013 SHALL, on a tick, advance digit_idx by 1 modulo NUM_DIGITS.
REQ-014 SHALL, with REFRESH_DIV=1, assert tick every cycle.
REQ-015 SHALL define a frame boundary as tick asserted while digit_idx equals NUM_DIGITS-1; frame_done is high for the cycle after that edge.
REQ-016 SHALL drive digit_en_n low only at bit digit_idx, all other bits high (unless blanked, see REQ-024).
REQ-017 SHALL drive digit_val with nibble digit_idx of shown_reg.
REQ-018 SHALL complete a transfer when load_valid and load_ready are both high on a rising edge: load_data goes into pending_reg, and pending_full is set.
REQ-019 SHALL drive load_ready as the inverse of pending_full.
REQ-020 SHALL, at a frame boundary with pending_full set, copy pending_reg into shown_reg and clear pending_full. The displayed value therefore never changes mid-frame.
REQ-021 SHALL, when a transfer and a frame boundary fall on the same edge with pending_full clear, store the new data in pending_reg only. It is applied at the next frame boundary.
REQ-022 SHALL ignore load_valid while load_ready is low; no data is lost or overwritten.

Reset
REQ-023 SHALL, while rst_n is low, immediately set: divider 0, digit_idx 0, shown_reg 0, pending_reg 0, pending_full 0, load_ready 1, digit_val 0, digit_en_n with only bit 0 low, frame_done 0. A pending value is discarded if reset occurs mid-frame.

Configuration
REQ-024 SHALL, when macro HEX_SCANNER_LZ_BLANK_EN is defined, blank leading zeros:
- a digit k>0 whose nibble and all higher nibbles of shown_reg are 0 drives digit_en_n all ones and digit_val 0;
- digit 0 is never blanked.
REQ-025 SHALL, when HEX_SCANNER_LZ_BLANK_EN is undefined, light every digit in turn regardless of value. No blanking logic is synthesized.

Structure
REQ-026 SHALL place NUM_DIGITS default, a digit-index typedef sized clog2(NUM_DIGITS), and the nibble typedef in shared package hex_scan_pkg.
REQ-027 SHALL implement the divider and tick generation as sub-module tick_gen, parameterized by REFRESH_DIV, with ports clk, rst_n and tick.

Verification
All scenarios use REFRESH_DIV=4 and NUM_DIGITS=8.
REQ-028 SHALL check reset with no loads:
- stimulus: release reset, no loads;
- response: digit_en_n=8'hFE and digit_val=0 for 4 cycles, then 8'hFD, wrapping after 32 cycles with one frame_done pulse.
REQ-029 SHALL check a basic load:
- stimulus: load 32'h1234_ABCD at cycle 5;
- response: load_ready low from next cycle; digits keep showing 0 until the first frame boundary; the following frame shows D,C,B,A,4,3,2,1 on digits 0..7; load_ready then high again.
REQ-030 SHALL check back-pressure:
- stimulus: a second load_valid with 32'hFFFF_FFFF while pending_full is set;
- response: ignored; the first value displays; a re-offer after load_ready rises is accepted.
REQ-031 SHALL check the simultaneous case:
- stimulus: a transfer on the exact frame-boundary edge;
- response: the value is not shown in the starting frame; it appears in the frame after.
REQ-032 SHALL check reset mid-operation:
- stimulus: assert rst_n low while pending_full is set;
- response: all outputs return to reset values asynchronously; after release the display shows 0.
REQ-033 SHALL check blanking with HEX_SCANNER_LZ_BLANK_EN defined:
- stimulus: load 32'h0000_00A5;
- response: digits 0..1 show 5,A; digits 2..7 have digit_en_n all ones.
- stimulus: load 0;
- response: only digit 0 lights, showing 0.

Source files
------------

// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the hex_scanner display multiplexer.
// Digit-count default, digit-index and nibble types, plus a width helper.
package hex_scan_pkg;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int DIGIT_IDX_W    = (NUM_DIGITS_DEF > 1) ? $clog2(NUM_DIGITS_DEF) : 1;

    typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;
    typedef logic [3:0]             nibble_t;

    // Counter width that stays at least one bit for degenerate ranges.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_scanner_tick_gen.sv
// Refresh divider: counts 0..REFRESH_DIV-1 and raises tick on the last count,
// wrapping to 0 on the same edge. REFRESH_DIV=1 gives a tick every cycle.
module tick_gen
    import hex_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               CNT_W = safe_clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_scanner.sv
// Multiplexed hex display scanner with a one-deep load buffer applied only at
// frame boundaries. Define HEX_SCANNER_LZ_BLANK_EN to blank leading zero digits.
module hex_scanner
    import hex_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    load_valid,
    output logic                    load_ready,
    output nibble_t                 digit_val,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic                    frame_done
);

    localparam int               IDX_W    = safe_clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                    tick;
    logic                    boundary;
    logic                    xfer;
    logic [IDX_W-1:0]        idx_q,          idx_d;
    logic [4*NUM_DIGITS-1:0] shown_q,        shown_d;
    logic [4*NUM_DIGITS-1:0] pending_q,      pending_d;
    logic                    pending_full_q, pending_full_d;
    logic                    frame_done_q,   frame_done_d;
    logic [NUM_DIGITS-1:0]   en_raw_n;
    nibble_t                 val_raw;

    tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        boundary       = tick && (idx_q == LAST_IDX);
        xfer           = load_valid && !pending_full_q;
        idx_d          = idx_q;
        shown_d        = shown_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_done_d   = boundary;

        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        // A full buffer drains at the boundary; an empty one can only fill,
        // so a load landing on the boundary edge waits one more frame.
        if (boundary && pending_full_q) begin
            shown_d        = pending_q;
            pending_full_d = 1'b0;
        end
        if (xfer) begin
            pending_d      = load_data;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q          <= '0;
            shown_q        <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            idx_q          <= idx_d;
            shown_q        <= shown_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_done_q   <= frame_done_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_en
            assign en_raw_n[gi] = (idx_q != IDX_W'(gi));
        end
    endgenerate

    assign val_raw    = shown_q[{idx_q, 2'b00} +: 4];
    assign load_ready = !pending_full_q;
    assign frame_done = frame_done_q;

`ifdef HEX_SCANNER_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  blank;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
            assign zero_from[gi] = (shown_q[4*NUM_DIGITS-1:4*gi] == '0);
        end
    endgenerate

    assign blank      = (idx_q != '0) && zero_from[idx_q];
    assign digit_en_n = blank ? '1 : en_raw_n;
    assign digit_val  = blank ? '0 : val_raw;
`else
    assign digit_en_n = en_raw_n;
    assign digit_val  = val_raw;
`endif

endmodule
